cmac_tx_pkt_arbiter: RTL and testbench

Packet-granular 2:1 AXI-Stream arbiter that shares the single CMAC TX stream between the host H2C path (port 0) and the UDP perf-monitor traffic path (port 1). It sits between the two 512-bit sources and the cross-die TX buffer in front of `CmacRxTxWrapper`. Once a port is granted, it holds the output until that packet's `tlast` beat, so packets are never interleaved. It also keeps per-port packet counters for the performance ILA.

---
 rtl/cmac_axis_pkg.sv | 16 +
 rtl/axis_out_reg.sv | 47 ++++
 rtl/cmac_tx_pkt_arbiter.sv | 146 ++++++++++++++
 tb/tb_cmac_tx_pkt_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_axis_pkg.sv
// Shared constants and types for the CMAC AXI-Stream TX/RX plumbing in the XDMA clock domain.
package cmac_axis_pkg;

  localparam int XDMA_AXIS_TDATA_WIDTH = 512;
  localparam int XDMA_AXIS_TKEEP_WIDTH = 64;
  localparam int XDMA_AXIS_TUSER_WIDTH = 1;

  localparam logic ARB_PORT_H2C  = 1'b0;
  localparam logic ARB_PORT_PERF = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-stage AXI-Stream output register: captures a beat when loaded and holds it
// stable until the downstream accepts it.
module axis_out_reg
  import cmac_axis_pkg::*;
#(
  parameter int DATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
  parameter int KEEP_WIDTH = XDMA_AXIS_TKEEP_WIDTH,
  parameter int USER_WIDTH = XDMA_AXIS_TUSER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic [KEEP_WIDTH-1:0] in_tkeep,
  input  logic                  in_tlast,
  input  logic [USER_WIDTH-1:0] in_tuser,
  output logic                  in_ready,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  // The register can take a new beat when empty or when its current beat leaves this cycle.
  assign in_ready = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= in_tdata;
      m_axis_tkeep  <= in_tkeep;
      m_axis_tlast  <= in_tlast;
      m_axis_tuser  <= in_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/cmac_tx_pkt_arbiter.sv
// Packet-granular 2:1 AXI-Stream arbiter sharing the CMAC TX stream between host H2C
// (port 0) and the UDP perf generator (port 1), with per-port packet counters.
module cmac_tx_pkt_arbiter
  import cmac_axis_pkg::*;
#(
  parameter int DATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
  parameter int KEEP_WIDTH = XDMA_AXIS_TKEEP_WIDTH,
  parameter int USER_WIDTH = XDMA_AXIS_TUSER_WIDTH
) (
  input  logic                  xdma_clk,
  input  logic                  xdma_reset,
  input  logic                  arb_enable,
  input  logic                  prio_mode,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  grant_id,
  output logic                  busy,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1
);

  // Every stream here obeys valid/ready: a beat transfers on a cycle where both are high,
  // and once valid is raised, valid and payload stay unchanged until that transfer.

  arb_state_t state;
  logic       last_grant;
  logic       sel_port;
  logic       out_ready;
  logic       accept;
  logic       pkt_done;

  logic                  in_valid;
  logic                  in_tlast;
  logic [DATA_WIDTH-1:0] in_tdata;
  logic [KEEP_WIDTH-1:0] in_tkeep;
  logic [USER_WIDTH-1:0] in_tuser;

  assign busy = (state == BUSY);

  // Round-robin ties go to the port that did not win last time; reset favours port 0.
  always_comb begin
    sel_port = ARB_PORT_H2C;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      sel_port = prio_mode ? ARB_PORT_H2C : ~last_grant;
    end else if (s1_axis_tvalid) begin
      sel_port = ARB_PORT_PERF;
    end
  end

  always_comb begin
    in_valid = s0_axis_tvalid;
    in_tlast = s0_axis_tlast;
    in_tdata = s0_axis_tdata;
    in_tkeep = s0_axis_tkeep;
    in_tuser = s0_axis_tuser;
    if (grant_id == ARB_PORT_PERF) begin
      in_valid = s1_axis_tvalid;
      in_tlast = s1_axis_tlast;
      in_tdata = s1_axis_tdata;
      in_tkeep = s1_axis_tkeep;
      in_tuser = s1_axis_tuser;
    end
  end

  assign s0_axis_tready = busy && (grant_id == ARB_PORT_H2C)  && out_ready;
  assign s1_axis_tready = busy && (grant_id == ARB_PORT_PERF) && out_ready;
  assign accept         = busy && out_ready && in_valid;
  assign pkt_done       = accept && in_tlast;

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      state      <= IDLE;
      grant_id   <= ARB_PORT_H2C;
      last_grant <= ARB_PORT_PERF;
    end else begin
      case (state)
        IDLE: begin
          if (arb_enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
            state      <= BUSY;
            grant_id   <= sel_port;
            last_grant <= sel_port;
          end
        end
        BUSY: begin
          // The grant is held until tlast, even if the source stalls indefinitely.
          if (pkt_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else begin
      if (pkt_done && (grant_id == ARB_PORT_H2C)) begin
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      end
      if (pkt_done && (grant_id == ARB_PORT_PERF)) begin
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_out_reg (
    .clk           (xdma_clk),
    .rst           (xdma_reset),
    .load          (accept),
    .in_tdata      (in_tdata),
    .in_tkeep      (in_tkeep),
    .in_tlast      (in_tlast),
    .in_tuser      (in_tuser),
    .in_ready      (out_ready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

endmodule

// File: tb/tb_cmac_tx_pkt_arbiter.sv
// Directed bench for cmac_tx_pkt_arbiter: queue-fed sources, output scoreboard,
// and cycle-exact checks of grant, latency, backpressure, enable, reset and counter wrap.
module tb_cmac_tx_pkt_arbiter;
  import cmac_axis_pkg::*;

  localparam int DW = XDMA_AXIS_TDATA_WIDTH;
  localparam int KW = XDMA_AXIS_TKEEP_WIDTH;
  localparam int UW = XDMA_AXIS_TUSER_WIDTH;
  localparam int BW = 1 + UW + KW + DW;
  typedef logic [BW-1:0] beat_t;

  // ---------------- clock / reset / DUT ----------------
  logic          xdma_clk = 1'b0;
  logic          xdma_reset = 1'b0;
  logic          arb_enable = 1'b1;
  logic          prio_mode = 1'b0;
  logic          s0_axis_tvalid = 1'b0, s0_axis_tlast = 1'b0;
  logic [DW-1:0] s0_axis_tdata = '0;
  logic [KW-1:0] s0_axis_tkeep = '0;
  logic [UW-1:0] s0_axis_tuser = '0;
  logic          s1_axis_tvalid = 1'b0, s1_axis_tlast = 1'b0;
  logic [DW-1:0] s1_axis_tdata = '0;
  logic [KW-1:0] s1_axis_tkeep = '0;
  logic [UW-1:0] s1_axis_tuser = '0;
  logic          s0_axis_tready, s1_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          grant_id, busy;
  logic [31:0]   pkt_cnt0, pkt_cnt1;

  always #5 xdma_clk = ~xdma_clk;

  cmac_tx_pkt_arbiter dut (
    .xdma_clk       (xdma_clk),
    .xdma_reset     (xdma_reset),
    .arb_enable     (arb_enable),
    .prio_mode      (prio_mode),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tuser  (s0_axis_tuser),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tuser  (s1_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .grant_id       (grant_id),
    .busy           (busy),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  int checks = 0;
  int errors = 0;

  beat_t src0_q[$];
  beat_t src1_q[$];
  beat_t exp_q[$];
  logic  grant_log[$];

  function automatic beat_t mk_beat(input int port, input int pkt, input int idx, input bit last);
    logic [63:0]   w;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    w = {16'hCAFE, 8'(port), 8'(pkt), 8'(idx), 24'h5A5A5A};
    k = last ? {{(KW-8){1'b0}}, 8'h0F} : '1;
    u = UW'(idx);
    return {last, u, k, {(DW/64){w}}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_src(input int port, input int pkt, input int n);
    for (int i = 0; i < n; i++) begin
      if (port == 0) src0_q.push_back(mk_beat(0, pkt, i, i == n - 1));
      else           src1_q.push_back(mk_beat(1, pkt, i, i == n - 1));
    end
  endtask

  task automatic push_exp(input int port, input int pkt, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(port, pkt, i, i == n - 1));
  endtask

  task automatic tick();
    @(posedge xdma_clk);
    #2;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge xdma_clk);
      n++;
    end
    chk(tag, 64'(busy), 64'(lvl));
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge xdma_clk);
      n++;
      done = (exp_q.size() == 0) && (src0_q.size() == 0) && (src1_q.size() == 0) &&
             !busy && !m_axis_tvalid;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  // Sources present the head of their queue; a beat is dropped once it was accepted.
  beat_t cur0, cur1, drop;
  logic  acc0, acc1;
  always begin
    @(negedge xdma_clk);
    acc0 = s0_axis_tvalid && s0_axis_tready;
    acc1 = s1_axis_tvalid && s1_axis_tready;
    @(posedge xdma_clk);
    #1;
    if (acc0 && src0_q.size() > 0) drop = src0_q.pop_front();
    if (acc1 && src1_q.size() > 0) drop = src1_q.pop_front();
    cur0 = (src0_q.size() > 0) ? src0_q[0] : '0;
    cur1 = (src1_q.size() > 0) ? src1_q[0] : '0;
    s0_axis_tvalid = (src0_q.size() > 0);
    s1_axis_tvalid = (src1_q.size() > 0);
    {s0_axis_tlast, s0_axis_tuser, s0_axis_tkeep, s0_axis_tdata} = cur0;
    {s1_axis_tlast, s1_axis_tuser, s1_axis_tkeep, s1_axis_tdata} = cur1;
  end

  // ---------------- scoreboard / output monitor ----------------
  beat_t got_beat, exp_beat, held_beat;
  logic  busy_q = 1'b0;
  logic  stall_q = 1'b0;
  int    stall_seen = 0;
  always @(negedge xdma_clk) begin
    if (xdma_reset) begin
      busy_q  = 1'b0;
      stall_q = 1'b0;
    end else begin
      got_beat = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
      if (busy && !busy_q) grant_log.push_back(grant_id);
      if (stall_q) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        checks++;
        assert (got_beat === held_beat) else begin
          errors++;
          $error("FAIL hold_data got %0h exp %0h", got_beat, held_beat);
        end
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        stall_seen++;
        chk("stall_tready", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL beat_unexpected got %0h exp none", got_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          assert (got_beat === exp_beat) else begin
            errors++;
            $error("FAIL beat got %0h exp %0h", got_beat, exp_beat);
          end
        end
      end
      busy_q    = busy;
      stall_q   = m_axis_tvalid && !m_axis_tready;
      held_beat = got_beat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [11:0] bp_pat;
  int          gl;
  initial begin
    #1 xdma_reset = 1'b1;
    @(negedge xdma_clk);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_grant",  64'(grant_id), 64'd0);
    chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_mlast",  64'(m_axis_tlast), 64'd0);
    chk("rst_mdata",  64'(m_axis_tdata == '0), 64'd1);
    chk("rst_mkeep",  64'(m_axis_tkeep), 64'd0);
    chk("rst_muser",  64'(m_axis_tuser), 64'd0);
    chk("rst_cnt0",   64'(pkt_cnt0), 64'd0);
    chk("rst_cnt1",   64'(pkt_cnt1), 64'd0);
    chk("rst_treadys", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
    tick();
    xdma_reset = 1'b0;

    // Single source, 3 beats: request visible N1, grant N2, beats out N3..N5.
    tick();
    push_src(0, 0, 3);
    push_exp(0, 0, 3);
    @(negedge xdma_clk);
    chk("ss_n0_valid", 64'(s0_axis_tvalid), 64'd0);
    @(negedge xdma_clk);
    chk("ss_n1_busy",   64'(busy), 64'd0);
    chk("ss_n1_valid",  64'(s0_axis_tvalid), 64'd1);
    chk("ss_n1_tready", 64'(s0_axis_tready), 64'd0);
    @(negedge xdma_clk);
    chk("ss_n2_busy",   64'(busy), 64'd1);
    chk("ss_n2_grant",  64'(grant_id), 64'd0);
    chk("ss_n2_tready", 64'(s0_axis_tready), 64'd1);
    chk("ss_n2_s1rdy",  64'(s1_axis_tready), 64'd0);
    chk("ss_n2_mvalid", 64'(m_axis_tvalid), 64'd0);
    @(negedge xdma_clk);
    chk("ss_n3_mvalid", 64'(m_axis_tvalid), 64'd1);
    chk("ss_n3_mlast",  64'(m_axis_tlast), 64'd0);
    @(negedge xdma_clk);
    chk("ss_n4_busy",   64'(busy), 64'd1);
    @(negedge xdma_clk);
    chk("ss_n5_busy",   64'(busy), 64'd0);
    chk("ss_n5_mvalid", 64'(m_axis_tvalid), 64'd1);
    chk("ss_n5_mlast",  64'(m_axis_tlast), 64'd1);
    chk("ss_n5_cnt0",   64'(pkt_cnt0), 64'd1);
    @(negedge xdma_clk);
    chk("ss_n6_mvalid", 64'(m_axis_tvalid), 64'd0);

    // Fresh reset so the first round-robin tie goes to port 0.
    tick();
    xdma_reset = 1'b1;
    tick();
    xdma_reset = 1'b0;
    chk("pulse_cnt0", 64'(pkt_cnt0), 64'd0);
    grant_log.delete();

    // Round-robin, both ports continuously valid.
    tick();
    for (int k = 0; k < 4; k++) begin
      push_src(0, k, 2);
      push_src(1, k, 2);
      push_exp(0, k, 2);
      push_exp(1, k, 2);
    end
    wait_drain(300, "rr_drain");
    chk("rr_cnt0", 64'(pkt_cnt0), 64'd4);
    chk("rr_cnt1", 64'(pkt_cnt1), 64'd4);
    chk("rr_ngrants", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      gl = (i < grant_log.size()) ? int'(grant_log[i]) : -1;
      chk("rr_grant_order", 64'(gl), 64'(i % 2));
    end

    // Strict priority: port 1 waits until port 0 runs dry.
    tick();
    grant_log.delete();
    prio_mode = 1'b1;
    for (int k = 10; k < 13; k++) begin
      push_src(0, k, 2);
      push_exp(0, k, 2);
    end
    push_src(1, 10, 2);
    push_exp(1, 10, 2);
    begin
      int n;
      n = 0;
      while (pkt_cnt0 != 32'd7 && n < 100) begin
        @(negedge xdma_clk);
        n++;
      end
    end
    chk("sp_cnt0", 64'(pkt_cnt0), 64'd7);
    chk("sp_cnt1_held", 64'(pkt_cnt1), 64'd4);
    wait_drain(100, "sp_drain");
    chk("sp_cnt1", 64'(pkt_cnt1), 64'd5);
    chk("sp_ngrants", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      gl = (i < grant_log.size()) ? int'(grant_log[i]) : -1;
      chk("sp_grant_order", 64'(gl), 64'(i == 3));
    end

    // Backpressure during a 4-beat packet.
    tick();
    prio_mode = 1'b0;
    stall_seen = 0;
    push_src(0, 20, 4);
    push_exp(0, 20, 4);
    wait_busy(1'b1, 50, "bp_grant");
    bp_pat = 12'b1111_0110_1001;
    for (int i = 0; i < 12; i++) begin
      tick();
      m_axis_tready = bp_pat[i];
    end
    tick();
    m_axis_tready = 1'b1;
    wait_drain(100, "bp_drain");
    chk("bp_stalled", 64'(stall_seen > 0), 64'd1);
    chk("bp_cnt0", 64'(pkt_cnt0), 64'd8);

    // Enable drop mid-packet; last_grant is port 0, so port 1 wins the tie.
    tick();
    push_src(0, 30, 4);
    push_src(1, 30, 4);
    push_src(1, 31, 2);
    push_exp(1, 30, 4);
    wait_busy(1'b1, 50, "en_grant");
    chk("en_grant_id", 64'(grant_id), 64'd1);
    tick();
    arb_enable = 1'b0;
    wait_busy(1'b0, 50, "en_finish");
    for (int i = 0; i < 5; i++) begin
      @(negedge xdma_clk);
      chk("en_idle_busy", 64'(busy), 64'd0);
      chk("en_both_valid", 64'({s0_axis_tvalid, s1_axis_tvalid}), 64'd3);
    end
    chk("en_cnt1", 64'(pkt_cnt1), 64'd6);
    chk("en_exp_empty", 64'(exp_q.size()), 64'd0);

    // Re-enable; port 0 wins, then reset lands mid-packet.
    tick();
    arb_enable = 1'b1;
    push_exp(0, 30, 4);
    wait_busy(1'b1, 50, "rs_grant");
    chk("rs_grant_id", 64'(grant_id), 64'd0);
    @(negedge xdma_clk);
    chk("rs_pre_mvalid", 64'(m_axis_tvalid), 64'd1);
    #2 xdma_reset = 1'b1;
    #1;
    chk("rs_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rs_mlast",  64'(m_axis_tlast), 64'd0);
    chk("rs_busy",   64'(busy), 64'd0);
    chk("rs_cnt0",   64'(pkt_cnt0), 64'd0);
    chk("rs_cnt1",   64'(pkt_cnt1), 64'd0);
    chk("rs_treadys", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    tick();
    tick();
    xdma_reset = 1'b0;

    // Counter wrap with a single-beat port-1 packet.
    tick();
    force dut.pkt_cnt1 = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt1;
    chk("wr_preset", 64'(pkt_cnt1), 64'hFFFF_FFFF);
    push_src(1, 40, 1);
    push_exp(1, 40, 1);
    @(negedge xdma_clk);
    @(negedge xdma_clk);
    chk("wr_n1_busy", 64'(busy), 64'd0);
    @(negedge xdma_clk);
    chk("wr_n2_busy",   64'(busy), 64'd1);
    chk("wr_n2_grant",  64'(grant_id), 64'd1);
    chk("wr_n2_treadys", 64'({s0_axis_tready, s1_axis_tready}), 64'd1);
    @(negedge xdma_clk);
    chk("wr_n3_busy",   64'(busy), 64'd0);
    chk("wr_n3_mvalid", 64'(m_axis_tvalid), 64'd1);
    chk("wr_n3_mlast",  64'(m_axis_tlast), 64'd1);
    chk("wr_n3_cnt1",   64'(pkt_cnt1), 64'd0);
    chk("wr_n3_cnt0",   64'(pkt_cnt0), 64'd0);
    @(negedge xdma_clk);
    chk("wr_n4_mvalid", 64'(m_axis_tvalid), 64'd0);
    wait_drain(20, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
